// File: rtl/ps2_keycode_queue.sv
// PS/2 scancode to ASCII translator feeding a show-ahead character FIFO.
// Tracks break/extended prefixes and a shared shift flag; only printable make codes are queued.
module ps2_keycode_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ps2_key_pressed,
   input  logic [7:0]        ps2_key_data,
   input  logic              rd_en,
   output logic [7:0]        ascii_out,
   output logic              valid,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              shift_active
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_BREAK     = 2'd1,
      S_EXT       = 2'd2,
      S_EXT_BREAK = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

   state_t              r_state;
   logic                r_shift;
   logic                r_pend_vld;
   logic [7:0]          r_pend_char;
   logic [7:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_count;
   logic                r_overflow;

   logic                w_rd;
   logic                w_wr;
   logic                w_full;
   logic                w_is_shift;
   logic [8:0]          w_xlate;

   // Bit 8 flags a printable hit; letters come out lowercase and are folded to uppercase by shift.
   function automatic logic [8:0] f_xlate(input logic [7:0] code, input logic shift);
      logic [7:0] ch;
      logic       hit;
      logic       letter;
      ch     = 8'h00;
      hit    = 1'b1;
      letter = 1'b1;
      case (code)
         8'h1C: ch = 8'h61;
         8'h32: ch = 8'h62;
         8'h21: ch = 8'h63;
         8'h23: ch = 8'h64;
         8'h24: ch = 8'h65;
         8'h2B: ch = 8'h66;
         8'h34: ch = 8'h67;
         8'h33: ch = 8'h68;
         8'h43: ch = 8'h69;
         8'h3B: ch = 8'h6A;
         8'h42: ch = 8'h6B;
         8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;
         8'h31: ch = 8'h6E;
         8'h44: ch = 8'h6F;
         8'h4D: ch = 8'h70;
         8'h15: ch = 8'h71;
         8'h2D: ch = 8'h72;
         8'h1B: ch = 8'h73;
         8'h2C: ch = 8'h74;
         8'h3C: ch = 8'h75;
         8'h2A: ch = 8'h76;
         8'h1D: ch = 8'h77;
         8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;
         8'h1A: ch = 8'h7A;
         default: letter = 1'b0;
      endcase
      if (!letter) begin
         case (code)
            8'h45: ch = 8'h30;
            8'h16: ch = 8'h31;
            8'h1E: ch = 8'h32;
            8'h26: ch = 8'h33;
            8'h25: ch = 8'h34;
            8'h2E: ch = 8'h35;
            8'h36: ch = 8'h36;
            8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38;
            8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            default: hit = 1'b0;
         endcase
      end else if (shift) begin
         ch = ch - 8'h20;
      end else begin
         ch = ch;
      end
      return {hit, ch};
   endfunction

   // Translation and FIFO handshake terms.
   always_comb begin
      w_xlate    = f_xlate(ps2_key_data, r_shift);
      w_is_shift = (ps2_key_data == 8'h12) || (ps2_key_data == 8'h59);
      w_full     = (r_count == C_FULL);
      w_rd       = rd_en && (r_count != {(ADDR_W+1){1'b0}});
      w_wr       = r_pend_vld && (!w_full || w_rd);
   end

   // Prefix FSM, shift flag and the one-entry pending character.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shift     <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_char <= 8'h00;
      end else begin
         r_pend_vld <= 1'b0;
         if (ps2_key_pressed) begin
            case (r_state)
               S_IDLE: begin
                  if (ps2_key_data == 8'hF0) begin
                     r_state <= S_BREAK;
                  end else if (ps2_key_data == 8'hE0) begin
                     r_state <= S_EXT;
                  end else if (w_is_shift) begin
                     r_shift <= 1'b1;
                  end else if (w_xlate[8]) begin
                     r_pend_vld  <= 1'b1;
                     r_pend_char <= w_xlate[7:0];
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_BREAK: begin
                  if (w_is_shift) begin
                     r_shift <= 1'b0;
                  end else begin
                     r_shift <= r_shift;
                  end
                  r_state <= S_IDLE;
               end
               S_EXT: begin
                  if (ps2_key_data == 8'hF0) begin
                     r_state <= S_EXT_BREAK;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_EXT_BREAK: r_state <= S_IDLE;
               default:     r_state <= S_IDLE;
            endcase
         end else begin
            r_state <= r_state;
         end
      end
   end

   // Pointers, occupancy and the sticky drop flag; a simultaneous pop frees the slot a full write needs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_ptr   <= {ADDR_W{1'b0}};
         r_wr_ptr   <= {ADDR_W{1'b0}};
         r_count    <= {(ADDR_W+1){1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{ADDR_W{1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
         if (r_pend_vld && !w_wr) begin
            r_overflow <= 1'b1;
         end else begin
            r_overflow <= r_overflow;
         end
      end
   end

   // Character storage; contents are don't-care until written since the output is gated by count.
   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= r_pend_char;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

   // Show-ahead head of queue.
   always_comb begin
      if (r_count != {(ADDR_W+1){1'b0}}) begin
         ascii_out = r_mem[r_rd_ptr];
      end else begin
         ascii_out = 8'h00;
      end
      valid        = (r_count != {(ADDR_W+1){1'b0}});
      count        = r_count;
      overflow     = r_overflow;
      shift_active = r_shift;
   end

endmodule

// File: doc/ps2_keycode_queue.md
# ps2_keycode_queue

Sits between the PS/2 keyboard controller and its consumers (processor keyboard port, LCD character path). It accepts raw scancode bytes from the PS/2 interface, tracks make/break/extended prefixes and shift state, translates make codes of printable keys into ASCII, and buffers the characters in a small show-ahead FIFO. Consumers pop characters with a single-cycle read strobe.

## Interface

- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2_key_pressed  in  1  one-cycle strobe: a new scancode byte is on ps2_key_data.
- ps2_key_data  in  8  scancode byte, valid when ps2_key_pressed=1.
- rd_en  in  1  pop head entry; ignored when valid=0.
- ascii_out  out  8  head-of-queue character; 8'h00 when empty.
- valid  out  1  queue non-empty.
- count  out  ADDR_W+1  entries held, 0..DEPTH.
- overflow  out  1  sticky; set when a character is dropped because the queue is full.
- shift_active  out  1  a shift key is currently held.

## Operation

- Prefix FSM, advanced only on ps2_key_pressed:
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is a make code, translated, then stay IDLE.
  - BREAK: the byte is a break code; 12 or 59 clears shift; -> IDLE; nothing enqueued.
  - EXT: F0 -> EXT_BREAK; any other byte is an extended make code, dropped; -> IDLE.
  - EXT_BREAK: the byte is dropped; -> IDLE.
- Shift: make code 12 or 59 sets shift_active; one shared flag; nothing enqueued.
- Translation of make codes in IDLE:
  - Letters map to lowercase 61-7A, or uppercase 41-5A when shift_active: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits ignore shift: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 -> 20 (space), 5A -> 0D (enter), 66 -> 08 (backspace).
  - Any other code is dropped silently, with no state change.
  - Typematic repeats of a make code enqueue one character per repeat.
- Translation result is registered (a one-entry pending register plus a write flag) before the FIFO write.
- FIFO: circular buffer with rd_ptr/wr_ptr of ADDR_W bits that wrap modulo DEPTH, and a separate count register.
  - Write when the pending flag is set and count<DEPTH.
  - If count==DEPTH the write is dropped and overflow is set.
  - Read when rd_en=1 and count>0; it advances rd_ptr.
  - Read and write in the same cycle, with count in 1..DEPTH-1: both occur and count is unchanged.
  - Same cycle at count==DEPTH: read and write both occur, no overflow.
  - Same cycle at count==0: write only.
- ascii_out is combinational from mem[rd_ptr] and is gated to 00 when count==0.
- overflow clears only on reset.

## Timing

- Reset (asynchronous assert) values:
  - FSM IDLE, shift_active 0, pending flag 0.
  - Pointers 0, count 0, valid 0, ascii_out 00, overflow 0.
- Reset mid-sequence (for example after F0 was received) forgets the prefix; the next byte is treated from IDLE.
- Latency: with the strobe sampled at edge N, the pending register loads at N and the FIFO writes at N+1. valid/count/ascii_out reflect the new entry after edge N+1 (2 cycles).
- Pop: with rd_en high at edge M, the next entry (or 00 and valid=0) is visible after edge M. A consumer may hold rd_en high to drain one entry per cycle.
- Back-to-back strobes on consecutive cycles are accepted; throughput is one byte per cycle.
- shift_active updates at the edge that samples the 12/59 byte. It affects any letter byte sampled at a later edge.

## Test plan

- Reset, then strobe 1C -> 2 cycles later valid=1, count=1, ascii_out=61. Pulse rd_en -> valid=0, ascii_out=00.
- Strobe 12, 1C, F0, 12, 1C, with rd_en=0 -> queue holds 41 then 61, count=2, shift_active=0 at end.
- Strobe F0 1C, E0 75, E0 F0 75, and 0E -> nothing enqueued, count=0, FSM back in IDLE.
- Enqueue 9 digits 16,1E,26,25,2E,36,3D,3E,46 with DEPTH=8 -> count=8, overflow=1. Drain yields 31..38 in order.
- At count=8, assert rd_en in the same cycle the pending write lands -> count stays 8, overflow unchanged, and wrap-around order is preserved.
- Strobe F0, assert reset for 1 cycle, release, strobe 29 -> queue holds 20 (F0 prefix forgotten).
